// File: rtl/bias_stream_ctrl_pkg.sv
// Shared types and constants for the bias ROM streamer.
package bias_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bias_state_e;

  localparam int BIAS_BUF_DEPTH = 2;
  localparam int BIAS_OCC_W     = $clog2(BIAS_BUF_DEPTH + 1);

endpackage

// File: rtl/bias_skid_buf.sv
// Two-entry registered FIFO; head is always r_q0 so the stream data is a flop.
module bias_skid_buf
  import bias_stream_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DW-1:0]         i_push_data,
  input  logic                  i_pop,
  output logic [BIAS_OCC_W-1:0] o_occ,
  output logic [DW-1:0]         o_head
);

  logic [DW-1:0]         r_q0;
  logic [DW-1:0]         r_q1;
  logic [BIAS_OCC_W-1:0] r_occ;

  // pop is only ever asserted with r_occ>0 and push only with free space
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_occ <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == '0) r_q0 <= i_push_data;
          else             r_q1 <= i_push_data;
          r_occ <= r_occ + 1'b1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_occ <= r_occ - 1'b1;
        end
        2'b11: begin
          if (r_occ == BIAS_OCC_W'(1)) begin
            r_q0 <= i_push_data;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_q0;

endmodule

// File: rtl/bias_stream_ctrl.sv
// Streams a registered bias ROM onto an ap_fifo output, REPEAT passes per start.
// Optional BIAS_CTRL_STATS_EN adds a saturating downstream-stall counter.
module bias_stream_ctrl
  import bias_stream_ctrl_pkg::*;
#(
  parameter int MEM_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int REPEAT     = 4,
  localparam int AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  localparam int RW        = $clog2(REPEAT + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic [AW-1:0]         bias_address,
  output logic                  bias_ce,
  input  logic [DATA_WIDTH-1:0] bias_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
`ifdef BIAS_CTRL_STATS_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int TOTAL = MEM_SIZE * REPEAT;
  localparam int CW    = $clog2(TOTAL + 1);

  bias_state_e           r_state;
  bias_state_e           w_next;
  logic [AW-1:0]         r_addr;
  logic [RW-1:0]         r_pass;
  logic [CW-1:0]         r_wr_cnt;
  logic                  r_inflight;
  logic [BIAS_OCC_W-1:0] w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_addr_wrap;
  logic                  w_last_issue;
  logic                  w_start;

  assign w_start      = (r_state == S_IDLE) && ap_start;
  assign w_pop        = (w_occ != '0) && output_V_full_n;
  // a read may only issue if its data is guaranteed a slot on arrival
  assign w_credit     = (3'(w_occ) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));
  assign w_issue      = (r_state == S_RUN) && w_credit;
  assign w_addr_wrap  = (r_addr == AW'(MEM_SIZE - 1));
  assign w_last_issue = w_issue && w_addr_wrap && (r_pass == RW'(REPEAT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ap_start) w_next = S_RUN;
      S_RUN:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && (r_wr_cnt == CW'(TOTAL - 1))) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_pass     <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr   <= '0;
        r_pass   <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_issue) begin
          if (w_addr_wrap) begin
            r_addr <= '0;
            r_pass <= r_pass + 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        if (w_pop) r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  bias_skid_buf #(.DW(DATA_WIDTH)) u_buf (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_push      (r_inflight),
    .i_push_data (bias_q),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

`ifdef BIAS_CTRL_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if ((w_occ != '0) && !output_V_full_n && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign ap_idle        = (r_state == S_IDLE);
  assign ap_done        = (r_state == S_DONE);
  assign ap_ready       = ap_done;
  assign bias_ce        = w_issue;
  assign bias_address   = r_addr;
  assign output_V_write = w_pop;
  assign output_V_din   = w_head;

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Directed bench: main 16x4 instance plus a 1x3 instance for the degenerate ROM size.
module tb_bias_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        ap_start, ap_done, ap_idle, ap_ready;
  logic [3:0]  addr;
  logic        ce;
  logic [15:0] q;
  logic [15:0] din;
  logic        full_n, write;
  logic [31:0] stall_cnt;

  logic        start1, done1, idle1, ready1;
  logic [0:0]  addr1;
  logic        ce1;
  logic [15:0] q1;
  logic [15:0] din1;
  logic        full1, write1;
  logic [31:0] stall_cnt1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt, done_cyc, ce_cnt, viol, occ_max, m_occ, m_inf;
  int          w1_cnt, w1_bad, a1_bad, d1_cnt;

  bias_stream_ctrl #(.MEM_SIZE(16), .DATA_WIDTH(16), .REPEAT(4)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .bias_address(addr), .bias_ce(ce),
    .bias_q(q), .output_V_din(din), .output_V_full_n(full_n), .output_V_write(write)
`ifdef BIAS_CTRL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  bias_stream_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(16), .REPEAT(3)) dut1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start1), .ap_done(done1),
    .ap_idle(idle1), .ap_ready(ready1), .bias_address(addr1), .bias_ce(ce1),
    .bias_q(q1), .output_V_din(din1), .output_V_full_n(full1), .output_V_write(write1)
`ifdef BIAS_CTRL_STATS_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

`ifndef BIAS_CTRL_STATS_EN
  assign stall_cnt  = '0;
  assign stall_cnt1 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM models: data is the cycle after ce
  always @(posedge clk) if (ce)  q  <= 16'h0100 + 16'(addr);
  always @(posedge clk) if (ce1) q1 <= 16'hABCD;

  always @(negedge clk) begin
    if (rst) begin
      m_occ = 0;
      m_inf = 0;
    end else begin
      if (write) begin
        wr_data.push_back(din);
        wr_cyc.push_back(cyc);
        if (m_occ == 0) viol++;
      end
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
      if (ce) ce_cnt++;
      if (ce && (m_occ + m_inf - int'(write)) >= 2) viol++;
      m_occ = m_occ + m_inf - int'(write);
      m_inf = int'(ce);
      if (m_occ > occ_max) occ_max = m_occ;
      if (write1) begin
        w1_cnt++;
        if (din1 !== 16'hABCD) w1_bad++;
      end
      if (addr1 !== 1'b0) a1_bad++;
      if (done1) d1_cnt++;
    end
  end

  task automatic clear_logs();
    wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = -1; ce_cnt = 0; viol = 0; occ_max = 0;
  endtask

  task automatic wait_done(input int want, input int bound, input string nm);
    int n = 0;
    while (done_cnt < want && n < bound) begin @(posedge clk); n++; end
    n_assert++;
    if (done_cnt < want) begin
      n_fail++; $display("FAIL %s_timeout: done_cnt=%0d required %0d", nm, done_cnt, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ap_start = 1'b0; full_n = 1'b1; start1 = 1'b0; full1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
    n_assert++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b/%b want 0/0", ap_done, ap_ready); end
    n_assert++; if (ce !== 1'b0 || addr !== 4'd0) begin n_fail++; $display("FAIL rst_rom: ce=%b addr=%0d want 0/0", ce, addr); end
    n_assert++; if (write !== 1'b0 || din !== 16'h0) begin n_fail++; $display("FAIL rst_stream: write=%b din=%h want 0/0000", write, din); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_seq(input string nm);
    n_assert++;
    if (wr_data.size() != 64) begin n_fail++; $display("FAIL %s_count: got %0d want 64", nm, wr_data.size()); end
    for (int i = 0; i < wr_data.size(); i++) begin
      n_assert++;
      if (wr_data[i] !== 16'h0100 + 16'(i % 16)) begin
        n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, wr_data[i], 16'h0100 + 16'(i % 16));
      end
    end
  endtask

  task automatic test_basic();
    int t;
    clear_logs(); full_n = 1'b1;
    @(posedge clk); #1 ap_start = 1'b1; t = cyc;
    @(posedge clk); #1 ap_start = 1'b0;
    wait_done(1, 300, "basic");
    repeat (3) @(posedge clk);
    #1;
    check_seq("basic");
    for (int i = 0; i < wr_cyc.size(); i++) begin
      n_assert++;
      if (wr_cyc[i] != t + 3 + i) begin n_fail++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], t + 3 + i); end
    end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    n_assert++; if (done_cyc != t + 67) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, t + 67); end
    n_assert++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle_after: got %b want 1", ap_idle); end
  endtask

  task automatic test_toggle();
    int n = 0;
    clear_logs(); full_n = 1'b1;
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0; full_n = 1'b0;
    while (done_cnt < 1 && n < 600) begin @(posedge clk); #1 full_n = ~full_n; n++; end
    n_assert++; if (done_cnt < 1) begin n_fail++; $display("FAIL toggle_timeout: done_cnt=%0d required 1", done_cnt); end
    full_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_seq("toggle");
    n_assert++; if (viol != 0) begin n_fail++; $display("FAIL toggle_credit: violations %0d want 0", viol); end
    n_assert++; if (occ_max > 2) begin n_fail++; $display("FAIL toggle_occ: max %0d want <=2", occ_max); end
  endtask

  task automatic test_stall();
    clear_logs();
    @(posedge clk); #1 ap_start = 1'b1; full_n = 1'b0;
    @(posedge clk); #1 ap_start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    n_assert++; if (ce_cnt != 2) begin n_fail++; $display("FAIL stall_reads: got %0d want 2", ce_cnt); end
    n_assert++; if (wr_data.size() != 0) begin n_fail++; $display("FAIL stall_nowrite: got %0d want 0", wr_data.size()); end
    full_n = 1'b1;
    wait_done(1, 300, "stall");
    repeat (2) @(posedge clk);
    #1;
    check_seq("stall");
`ifdef BIAS_CTRL_STATS_EN
    n_assert++; if (stall_cnt !== 32'd20) begin n_fail++; $display("FAIL stall_cnt: got %0d want 20", stall_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_logs(); full_n = 1'b1;
    @(posedge clk); #1 ap_start = 1'b1;
    while (done_cnt < 2 && n < 400) begin @(posedge clk); n++; end
    #1 ap_start = 1'b0;
    n_assert++; if (done_cnt < 2) begin n_fail++; $display("FAIL b2b_timeout: done_cnt=%0d required 2", done_cnt); end
    repeat (10) @(posedge clk);
    #1;
    n_assert++; if (wr_data.size() != 128) begin n_fail++; $display("FAIL b2b_count: got %0d want 128", wr_data.size()); end
    n_assert++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
    for (int i = 0; i < wr_data.size(); i++) begin
      n_assert++;
      if (wr_data[i] !== 16'h0100 + 16'(i % 16)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wr_data[i], 16'h0100 + 16'(i % 16)); end
    end
  endtask

  task automatic test_midrun_start();
    int n = 0;
    clear_logs();
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    while (wr_data.size() < 30 && n < 200) begin @(posedge clk); n++; end
    #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    wait_done(1, 300, "midstart");
    repeat (20) @(posedge clk);
    #1;
    check_seq("midstart");
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL midstart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    clear_logs();
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    while (wr_data.size() < 10 && n < 200) begin @(posedge clk); n++; end
    #3 rst = 1'b1;
    #1;
    n_assert++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: idle=%b done=%b want 1/0", ap_idle, ap_done); end
    n_assert++; if (ce !== 1'b0 || addr !== 4'd0) begin n_fail++; $display("FAIL rstmid_rom: ce=%b addr=%0d want 0/0", ce, addr); end
    n_assert++; if (write !== 1'b0 || din !== 16'h0) begin n_fail++; $display("FAIL rstmid_stream: write=%b din=%h want 0/0000", write, din); end
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    wait_done(1, 300, "rstmid");
    repeat (2) @(posedge clk);
    #1;
    check_seq("rstmid");
  endtask

  task automatic test_mem1();
    int n = 0;
    w1_cnt = 0; w1_bad = 0; a1_bad = 0; d1_cnt = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    while (d1_cnt < 1 && n < 100) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    n_assert++; if (w1_cnt != 3) begin n_fail++; $display("FAIL mem1_count: got %0d want 3", w1_cnt); end
    n_assert++; if (w1_bad != 0) begin n_fail++; $display("FAIL mem1_data: bad %0d want 0", w1_bad); end
    n_assert++; if (a1_bad != 0) begin n_fail++; $display("FAIL mem1_addr: nonzero %0d want 0", a1_bad); end
    n_assert++; if (d1_cnt != 1) begin n_fail++; $display("FAIL mem1_done: got %0d want 1", d1_cnt); end
    n_assert++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL mem1_idle: got %b want 1", idle1); end
  endtask

  initial begin
    clear_logs();
    m_occ = 0; m_inf = 0;
    w1_cnt = 0; w1_bad = 0; a1_bad = 0; d1_cnt = 0;
    test_reset();
    test_basic();
    test_toggle();
    test_stall();
    test_back_to_back();
    test_midrun_start();
    test_reset_midrun();
    test_mem1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
